// File: rtl/spi_pkg.sv
// Shared definitions for the multi-slave SPI master: FSM encodings, mode bit
// positions and the half-period calculation used when a frame is accepted.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_GAP,
    CS_SETUP,
    SHIFT,
    CS_END
  } state_t;

  localparam int unsigned MODE_CPHA = 0;
  localparam int unsigned MODE_CPOL = 1;

  // Half period in clk cycles; a zero result from the shift is clamped to one.
  function automatic logic [31:0] spi_half_period(input logic [31:0] p, input logic [3:0] speed);
    logic [31:0] h;
    h = p >> speed;
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Restartable divider: one-cycle tick every `half` cycles, first tick `half`
// cycles after the restart pulse is released.
module spi_clk_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [31:0] half,
  output logic        tick_c
);

  logic [31:0] cnt;

  assign tick_c = (cnt == 32'd0) && !restart;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == 32'd0) begin
      cnt <= half - 32'd1;
    end else begin
      cnt <= cnt - 32'd1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with run-time mode/bit order/speed, decoded chip selects and
// optional chip-select hold between frames. One frame per start handshake.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int unsigned FREQ    = 48_000_000,
  parameter int unsigned BASE_HZ = 200_000,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_CS  = 4,
  localparam int unsigned CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  output logic              O_sck,
  output logic              O_mosi,
  input  logic              I_miso,
  output logic [NUM_CS-1:0] O_cs_n,
  input  logic [1:0]        I_mode,
  input  logic              I_lsb_first,
  input  logic [3:0]        I_speed,
  input  logic [CSW-1:0]    I_cs_sel,
  input  logic              I_cs_hold,
  input  logic              I_cs_release,
  input  logic              I_start,
  input  logic [WIDTH-1:0]  I_data_out,
  output logic [WIDTH-1:0]  O_data_in,
  output logic              O_busy,
  output logic              O_data_ready,
  input  logic              I_ack_read
);

  localparam int unsigned P  = FREQ / (BASE_HZ * 2);
  localparam int unsigned EW = $clog2(2 * WIDTH);

  state_t           state;
  logic [1:0]       mode_q;
  logic             lsb_q;
  logic [CSW-1:0]   sel_q;
  logic [CSW-1:0]   held_sel;
  logic             hold_q;
  logic             held;
  logic             rel_pend;
  logic             restart;
  logic [31:0]      half;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] rx_next;
  logic [EW-1:0]    edge_cnt;
  logic             tick_c;
  logic             leading;
  logic             last_edge;
  logic             sample;
  logic             drive;

  spi_clk_div u_div (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .restart(restart),
    .half   (half),
    .tick_c (tick_c)
  );

  function automatic logic head(input logic [WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // Selects outside the populated range leave every chip select high.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CSW-1:0] s);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (s == CSW'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Edge classification within SHIFT; odd-numbered edges (even count) lead.
  always_comb begin
    leading   = !edge_cnt[0];
    last_edge = (edge_cnt == EW'(2 * WIDTH - 1));
    sample    = mode_q[MODE_CPHA] ? !leading : leading;
    drive     = mode_q[MODE_CPHA] ? leading : (!leading && !last_edge);
    rx_next   = rx_q;
    if (sample) begin
      rx_next = lsb_q ? {I_miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], I_miso};
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state        <= IDLE;
      O_sck        <= 1'b0;
      O_mosi       <= 1'b1;
      O_cs_n       <= '1;
      O_busy       <= 1'b1;
      O_data_in    <= '0;
      O_data_ready <= 1'b0;
      mode_q       <= '0;
      lsb_q        <= 1'b0;
      sel_q        <= '0;
      held_sel     <= '0;
      hold_q       <= 1'b0;
      held         <= 1'b0;
      rel_pend     <= 1'b0;
      restart      <= 1'b0;
      half         <= 32'd1;
      tx_q         <= '0;
      rx_q         <= '0;
      edge_cnt     <= '0;
    end else begin
      restart <= 1'b0;
      if (I_ack_read) O_data_ready <= 1'b0;

      case (state)
        IDLE: begin
          O_busy <= 1'b0;
          O_sck  <= I_mode[MODE_CPOL];
          if (I_start && !O_busy) begin
            mode_q   <= I_mode;
            lsb_q    <= I_lsb_first;
            sel_q    <= I_cs_sel;
            hold_q   <= I_cs_hold;
            half     <= spi_half_period(32'(P), I_speed);
            restart  <= 1'b1;
            O_busy   <= 1'b1;
            rel_pend <= 1'b0;
            held     <= 1'b0;
            tx_q     <= I_data_out;
            rx_q     <= '0;
            if (held && held_sel != I_cs_sel) begin
              O_cs_n <= '1;
              state  <= CS_GAP;
            end else begin
              O_cs_n   <= cs_mask(I_cs_sel);
              edge_cnt <= '0;
              state    <= CS_SETUP;
              if (!I_mode[MODE_CPHA]) begin
                O_mosi <= head(I_data_out, I_lsb_first);
                tx_q   <= advance(I_data_out, I_lsb_first);
              end
            end
          end else if (I_cs_release && held) begin
            rel_pend <= 1'b1;
            restart  <= 1'b1;
          end else if (rel_pend && tick_c) begin
            O_cs_n   <= '1;
            held     <= 1'b0;
            rel_pend <= 1'b0;
          end
        end

        CS_GAP: begin
          if (tick_c) begin
            O_cs_n   <= cs_mask(sel_q);
            edge_cnt <= '0;
            state    <= CS_SETUP;
            if (!mode_q[MODE_CPHA]) begin
              O_mosi <= head(tx_q, lsb_q);
              tx_q   <= advance(tx_q, lsb_q);
            end
          end
        end

        CS_SETUP: begin
          if (tick_c) state <= SHIFT;
        end

        SHIFT: begin
          if (tick_c) begin
            O_sck    <= ~O_sck;
            edge_cnt <= edge_cnt + EW'(1);
            rx_q     <= rx_next;
            if (drive) begin
              O_mosi <= head(tx_q, lsb_q);
              tx_q   <= advance(tx_q, lsb_q);
            end
            if (last_edge) begin
              O_data_in    <= rx_next;
              O_data_ready <= 1'b1;
              O_mosi       <= 1'b1;
              state        <= CS_END;
            end
          end
        end

        CS_END: begin
          if (tick_c) begin
            if (hold_q) begin
              held     <= 1'b1;
              held_sel <= sel_q;
            end else begin
              O_cs_n <= '1;
            end
            O_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
